// File: rtl/layer_seq.sv
`timescale 1ns/1ps
// layer_seq: feeds one input vector to a layer of neurons over a shared
// broadcast bus, gathers every neuron's result, then streams the results
// downstream in neuron order with a last marker on the final beat.
module layer_seq #(
  parameter int layerNo       = 2,
  parameter int numNeuron     = 30,
  parameter int numWeight     = 30,
  parameter int dataWidth     = 16,
  parameter int timeoutCycles = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [dataWidth-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [dataWidth-1:0]           neuron_input,
  output logic                           neuron_input_valid,
  input  logic [numNeuron*dataWidth-1:0] neuron_out,
  input  logic [numNeuron-1:0]           neuron_outvalid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           layer_done,
  output logic                           timeout_err
);

  localparam int FEED_W = $clog2(numWeight + 1);
  localparam int IDX_W  = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam int WAIT_W = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;

  localparam logic [FEED_W-1:0] FEED_LAST = FEED_W'(numWeight - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(numNeuron - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(timeoutCycles - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // layerNo only labels the instance; the checks reject degenerate layers
  if (numNeuron < 1 || numWeight < 1 || timeoutCycles < 1 || layerNo < 0) begin : g_param_check
    $error("layer_seq: invalid parameterisation");
  end

  logic [1:0]                            state;
  logic [FEED_W-1:0]                     feed_cnt;
  logic [WAIT_W-1:0]                     wait_cnt;
  logic [IDX_W-1:0]                      idx;
  logic [IDX_W-1:0]                      idx_inc;
  logic [numNeuron-1:0]                  captured;
  logic [numNeuron-1:0]                  captured_next;
  logic [numNeuron-1:0][dataWidth-1:0]   cap;
  logic [numNeuron-1:0][dataWidth-1:0]   cap_next;
  logic                                  all_captured;

  assign idx_inc      = idx + 1'b1;
  assign all_captured = &captured_next;

  // Merge this cycle's first-time neuron results into the capture set (WAIT only)
  always_comb begin
    captured_next = captured;
    cap_next      = cap;
    if (state == S_WAIT) begin
      for (int i = 0; i < numNeuron; i++) begin
        if (neuron_outvalid[i] && !captured[i]) begin
          cap_next[i]      = neuron_out[i*dataWidth +: dataWidth];
          captured_next[i] = 1'b1;
        end
      end
    end
  end

  // Sequencer: feed the vector, collect results, drain them downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      feed_cnt           <= '0;
      wait_cnt           <= '0;
      idx                <= '0;
      captured           <= '0;
      cap                <= '0;
      in_ready           <= 1'b0;
      neuron_input       <= '0;
      neuron_input_valid <= 1'b0;
      out_data           <= '0;
      out_valid          <= 1'b0;
      out_last           <= 1'b0;
      busy               <= 1'b0;
      layer_done         <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      neuron_input_valid <= 1'b0;
      layer_done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_FEED;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            feed_cnt <= '0;
          end
        end
        S_FEED: begin
          if (in_valid && in_ready) begin
            neuron_input       <= in_data;
            neuron_input_valid <= 1'b1;
            if (feed_cnt == FEED_LAST) begin
              in_ready <= 1'b0;
              state    <= S_WAIT;
              feed_cnt <= '0;
              wait_cnt <= '0;
            end else begin
              feed_cnt <= feed_cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          cap      <= cap_next;
          captured <= captured_next;
          wait_cnt <= wait_cnt + 1'b1;
          if (all_captured || wait_cnt == WAIT_LAST) begin
            if (!all_captured) begin
              timeout_err <= 1'b1;
            end
            state     <= S_DRAIN;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= cap_next[0];
            out_last  <= (numNeuron == 1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == IDX_LAST) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              captured   <= '0;
              cap        <= '0;
              idx        <= '0;
              busy       <= 1'b0;
              layer_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              idx      <= idx_inc;
              out_data <= cap[idx_inc];
              out_last <= (idx_inc == IDX_LAST);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_seq.sv
`timescale 1ns/1ps
// Directed testbench for layer_seq with a 3-neuron, 4-weight layer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_layer_seq;

  localparam int NN = 3;
  localparam int NW = 4;
  localparam int DW = 16;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     neuron_input;
  logic              neuron_input_valid;
  logic [NN*DW-1:0]  neuron_out;
  logic [NN-1:0]     neuron_outvalid;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              layer_done;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  layer_seq #(
    .layerNo(2), .numNeuron(NN), .numWeight(NW), .dataWidth(DW), .timeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .neuron_input(neuron_input), .neuron_input_valid(neuron_input_valid),
    .neuron_out(neuron_out), .neuron_outvalid(neuron_outvalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .layer_done(layer_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Single comparison point: count it, report a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one element and wait (bounded) for it to be accepted and broadcast
  task automatic applyStimulus(input logic [DW-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 20 && !done; c++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    checkOutput("accept", done, 1);
    checkOutput("bcast_valid", neuron_input_valid, 1);
    checkOutput("bcast_data", neuron_input, d);
  endtask

  // Feed a whole vector, optionally with a one-cycle gap after each element
  task automatic feedVector(input logic [DW-1:0] v0, v1, v2, v3, input bit gaps);
    logic [DW-1:0] v [NW];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int k = 0; k < NW; k++) begin
      applyStimulus(v[k]);
      if (k < NW - 1) begin
        checkOutput("in_ready_feed", in_ready, 1);
        if (gaps) begin
          in_valid = 1'b0;
          @(negedge clk);
          checkOutput("gap_bcast_valid", neuron_input_valid, 0);
          checkOutput("gap_bcast_hold", neuron_input, v[k]);
          checkOutput("gap_in_ready", in_ready, 1);
        end
      end else begin
        in_valid = 1'b0;
        checkOutput("in_ready_wait", in_ready, 0);
        checkOutput("busy_wait", busy, 1);
      end
    end
  endtask

  // Collect the output vector, optionally stalling 5 cycles on one beat
  task automatic drainVector(input logic [DW-1:0] e0, e1, e2, input int stallBeat);
    logic [DW-1:0] e [NN];
    e[0] = e0; e[1] = e1; e[2] = e2;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && !out_valid; c++) @(negedge clk);
    checkOutput("drain_start", out_valid, 1);
    for (int b = 0; b < NN; b++) begin
      if (b == stallBeat) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_valid", out_valid, 1);
          checkOutput("stall_data", out_data, e[b]);
          checkOutput("stall_last", out_last, b == NN - 1);
        end
        out_ready = 1'b1;
      end
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_data", out_data, e[b]);
      checkOutput("out_last", out_last, b == NN - 1);
      checkOutput("done_early", layer_done, 0);
      @(negedge clk);
    end
    checkOutput("layer_done", layer_done, 1);
    checkOutput("out_valid_end", out_valid, 0);
    checkOutput("out_last_end", out_last, 0);
    checkOutput("busy_end", busy, 0);
    @(negedge clk);
    checkOutput("layer_done_pulse", layer_done, 0);
  endtask

  initial begin
    rst             = 1'b1;
    in_data         = '0;
    in_valid        = 1'b0;
    neuron_out      = '0;
    neuron_outvalid = '0;
    out_ready       = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_bcast_valid", neuron_input_valid, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_out_data", out_data, 0);
    rst = 1'b0;

    // Vector 1: back-to-back feed, staggered neuron results
    $display("[TB] vector 1: back-to-back feed, staggered captures");
    in_valid = 1'b1;
    in_data  = 16'h0100;
    @(negedge clk);
    checkOutput("idle_to_feed_ready", in_ready, 1);
    checkOutput("idle_no_consume", neuron_input_valid, 0);
    checkOutput("busy_feed", busy, 1);
    feedVector(16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0);
    neuron_outvalid = 3'b100;
    neuron_out[2*DW +: DW] = 16'h00AA;
    @(negedge clk);
    neuron_outvalid = '0;
    @(negedge clk);
    checkOutput("wait_no_out", out_valid, 0);
    neuron_outvalid = 3'b101;
    neuron_out[0*DW +: DW] = 16'h00BB;
    neuron_out[2*DW +: DW] = 16'hFFFF;
    @(negedge clk);
    neuron_outvalid = '0;
    repeat (2) @(negedge clk);
    checkOutput("wait_partial", out_valid, 0);
    neuron_outvalid = 3'b010;
    neuron_out[1*DW +: DW] = 16'h00CC;
    @(negedge clk);
    neuron_outvalid = '0;
    checkOutput("drain_entry", out_valid, 1);
    drainVector(16'h00BB, 16'h00CC, 16'h00AA, -1);

    // Vector 2: gapped feed, simultaneous captures, stalled drain
    $display("[TB] vector 2: gapped feed, stalled drain");
    feedVector(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1);
    neuron_outvalid = 3'b111;
    neuron_out = {16'h0003, 16'h0002, 16'h0001};
    @(negedge clk);
    neuron_out = {16'hDEAD, 16'hDEAD, 16'hDEAD};
    drainVector(16'h0001, 16'h0002, 16'h0003, 1);

    // Vector 3: neuron 1 never answers, so WAIT times out
    $display("[TB] vector 3: timeout with a silent neuron");
    feedVector(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 1'b0);
    neuron_outvalid = 3'b101;
    neuron_out = {16'h6666, 16'hDEAD, 16'h5555};
    repeat (TO - 1) begin
      @(negedge clk);
      neuron_outvalid = '0;
    end
    checkOutput("pre_timeout_err", timeout_err, 0);
    checkOutput("pre_timeout_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("timeout_err", timeout_err, 1);
    checkOutput("timeout_drain", out_valid, 1);
    drainVector(16'h5555, 16'h0000, 16'h6666, -1);
    checkOutput("timeout_sticky", timeout_err, 1);

    // Vector 4: asynchronous reset after two accepts, then a full vector
    $display("[TB] vector 4: reset mid-feed");
    applyStimulus(16'h0101);
    applyStimulus(16'h0202);
    checkOutput("timeout_next_vec", timeout_err, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_in_ready", in_ready, 0);
    checkOutput("arst_bcast_valid", neuron_input_valid, 0);
    checkOutput("arst_bcast_data", neuron_input, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_timeout", timeout_err, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", busy, 0);
    feedVector(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    neuron_outvalid = 3'b111;
    neuron_out = {16'h0009, 16'h0008, 16'h0007};
    @(negedge clk);
    neuron_outvalid = '0;
    drainVector(16'h0007, 16'h0008, 16'h0009, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
